// File: rtl/avg_frame_seq.sv
// Frame sequencer for the AVG core: starts the core on vsync, forwards queued
// lines to the drawer, and reports frame completion plus sticky error flags.
module avg_frame_seq #(
  parameter logic [15:0] TIMEOUT    = 16'd50000,
  parameter logic [5:0]  START_WAIT = 6'd48,
  parameter int          CNT_W      = 12
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             frame_start,
  input  logic             avg_halt,
  input  logic             lr_write,
  input  logic             q_empty,
  input  logic             q_full,
  input  logic             draw_ack,
  input  logic             clr_status,
  output logic             vggo,
  output logic             q_read,
  output logic             draw_req,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] line_count,
  output logic [CNT_W-1:0] frame_lines,
  output logic             overrun,
  output logic             timeout,
  output logic             start_fail,
  output logic             drop
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ARM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [5:0]  wait_cnt_r;
  logic [15:0] run_cnt_r;
  logic        lr_write_d_r;
  logic        wait_exp_s;
  logic        run_exp_s;
  logic        active_s;
  logic        start_fail_set_s;
  logic        timeout_set_s;
  logic        overrun_set_s;
  logic        drop_set_s;

  function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
    if (set) begin
      return 1'b1;
    end else if (clr) begin
      return 1'b0;
    end else begin
      return cur;
    end
  endfunction

  // Counters hold the cycle count already spent in ARM/RUN, so the limit hits on the Nth cycle.
  assign wait_exp_s = (wait_cnt_r >= (START_WAIT - 6'd1));
  assign run_exp_s  = (run_cnt_r >= (TIMEOUT - 16'd1));

  assign active_s      = (state_r == ST_ARM) || (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign draw_req      = active_s && !q_empty;
  assign q_read        = draw_req && draw_ack;
  assign overrun_set_s = frame_start && (state_r != ST_IDLE);
  assign drop_set_s    = lr_write && !lr_write_d_r && q_full;

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and error-event detection
  always_comb begin
    state_s          = state_r;
    start_fail_set_s = 1'b0;
    timeout_set_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (frame_start) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: state_s = ST_ARM;
      ST_ARM: begin
        if (!avg_halt) begin
          state_s = ST_RUN;
        end else if (wait_exp_s) begin
          state_s          = ST_DRAIN;
          start_fail_set_s = 1'b1;
        end else begin
          state_s = ST_ARM;
        end
      end
      ST_RUN: begin
        if (avg_halt) begin
          state_s = ST_DRAIN;
        end else if (run_exp_s) begin
          state_s       = ST_DRAIN;
          timeout_set_s = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (q_empty) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Saturating wait/run counters and line-write edge register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wait_cnt_r   <= 6'd0;
      run_cnt_r    <= 16'd0;
      lr_write_d_r <= 1'b0;
    end else begin
      lr_write_d_r <= lr_write;
      if (state_r == ST_START) begin
        wait_cnt_r <= 6'd0;
        run_cnt_r  <= 16'd0;
      end else begin
        if ((state_r == ST_ARM) && (wait_cnt_r != 6'h3f)) begin
          wait_cnt_r <= wait_cnt_r + 6'd1;
        end
        if ((state_r == ST_RUN) && (run_cnt_r != 16'hffff)) begin
          run_cnt_r <= run_cnt_r + 16'd1;
        end
      end
    end
  end

  // Line accounting
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      line_count  <= {CNT_W{1'b0}};
      frame_lines <= {CNT_W{1'b0}};
    end else begin
      if (state_r == ST_START) begin
        line_count <= {CNT_W{1'b0}};
      end else if (q_read && (line_count != {CNT_W{1'b1}})) begin
        line_count <= line_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (state_r == ST_DONE) begin
        frame_lines <= line_count;
      end
    end
  end

  // Registered status outputs, decoded from the state being entered
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vggo       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      start_fail <= 1'b0;
      drop       <= 1'b0;
    end else begin
      vggo       <= (state_s == ST_START);
      busy       <= (state_s != ST_IDLE);
      frame_done <= (state_s == ST_DONE);
      overrun    <= sticky_next(overrun, overrun_set_s, clr_status);
      timeout    <= sticky_next(timeout, timeout_set_s, clr_status);
      start_fail <= sticky_next(start_fail, start_fail_set_s, clr_status);
      drop       <= sticky_next(drop, drop_set_s, clr_status);
    end
  end

endmodule

// File: tb/tb_avg_frame_seq.sv
// Directed bench for avg_frame_seq: a phase-level frame model is compared with
// every DUT output each cycle, and scenario totals are pinned by literals.
module tb_avg_frame_seq;

  localparam int CNT_W = 12;
  localparam int TO    = 100;
  localparam int SW    = 48;
  localparam int QDEP  = 4;

  localparam int P_IDLE  = 0;
  localparam int P_START = 1;
  localparam int P_ARM   = 2;
  localparam int P_RUN   = 3;
  localparam int P_DRAIN = 4;
  localparam int P_DONE  = 5;

  logic clk_in = 1'b0;
  logic rst_in, frame_start, avg_halt, lr_write, q_empty, q_full, draw_ack, clr_status;
  logic vggo, q_read, draw_req, busy, frame_done;
  logic [CNT_W-1:0] line_count, frame_lines;
  logic overrun, timeout, start_fail, drop;

  int checks = 0;
  int passed = 0;
  int q_count = 0;
  int push_n = 0;
  int n_vggo, n_qread, n_done;

  // frame model: phase, cycles spent in it, and the expected registered outputs
  int m_ph, m_age, m_lc, m_fl;
  bit m_vggo, m_busy, m_done, m_ovr, m_to, m_sf, m_drop, m_lrp;

  avg_frame_seq #(.TIMEOUT(16'd100), .START_WAIT(6'd48), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start(frame_start), .avg_halt(avg_halt),
    .lr_write(lr_write), .q_empty(q_empty), .q_full(q_full), .draw_ack(draw_ack),
    .clr_status(clr_status), .vggo(vggo), .q_read(q_read), .draw_req(draw_req),
    .busy(busy), .frame_done(frame_done), .line_count(line_count),
    .frame_lines(frame_lines), .overrun(overrun), .timeout(timeout),
    .start_fail(start_fail), .drop(drop)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_age = 0; m_lc = 0; m_fl = 0;
    m_vggo = 0; m_busy = 0; m_done = 0;
    m_ovr = 0; m_to = 0; m_sf = 0; m_drop = 0; m_lrp = 0;
  endtask

  task automatic model_step();
    int  nph;
    bit  rd, sf_ev, to_ev, ov_ev, dr_ev;
    if (rst_in) begin
      model_reset();
      return;
    end
    nph   = m_ph;
    sf_ev = 0;
    to_ev = 0;
    rd    = (m_ph == P_ARM || m_ph == P_RUN || m_ph == P_DRAIN) && !q_empty && draw_ack;
    ov_ev = frame_start && (m_ph != P_IDLE);
    dr_ev = lr_write && !m_lrp && q_full;
    m_lrp = lr_write;
    case (m_ph)
      P_IDLE:  if (frame_start) nph = P_START;
      P_START: nph = P_ARM;
      P_ARM: begin
        m_age++;
        if (!avg_halt) nph = P_RUN;
        else if (m_age >= SW) begin nph = P_DRAIN; sf_ev = 1; end
      end
      P_RUN: begin
        m_age++;
        if (avg_halt) nph = P_DRAIN;
        else if (m_age >= TO) begin nph = P_DRAIN; to_ev = 1; end
      end
      P_DRAIN: if (q_empty) nph = P_DONE;
      default: nph = P_IDLE;
    endcase
    if (m_ph == P_DONE) m_fl = m_lc;
    if (m_ph == P_START) m_lc = 0;
    else if (rd && m_lc < (1 << CNT_W) - 1) m_lc++;
    m_ovr  = ov_ev ? 1'b1 : (clr_status ? 1'b0 : m_ovr);
    m_drop = dr_ev ? 1'b1 : (clr_status ? 1'b0 : m_drop);
    m_sf   = sf_ev ? 1'b1 : (clr_status ? 1'b0 : m_sf);
    m_to   = to_ev ? 1'b1 : (clr_status ? 1'b0 : m_to);
    if (nph != m_ph) m_age = 0;
    m_ph   = nph;
    m_vggo = (m_ph == P_START);
    m_busy = (m_ph != P_IDLE);
    m_done = (m_ph == P_DONE);
  endtask

  task automatic compare_all();
    bit exp_dr;
    exp_dr = (m_ph == P_ARM || m_ph == P_RUN || m_ph == P_DRAIN) && !q_empty;
    chk("vggo", vggo, m_vggo);
    chk("draw_req", draw_req, exp_dr);
    chk("q_read", q_read, exp_dr && draw_ack);
    chk("busy", busy, m_busy);
    chk("frame_done", frame_done, m_done);
    chk("line_count", line_count, m_lc);
    chk("frame_lines", frame_lines, m_fl);
    chk("overrun", overrun, m_ovr);
    chk("timeout", timeout, m_to);
    chk("start_fail", start_fail, m_sf);
    chk("drop", drop, m_drop);
  endtask

  // One clock: compare at the falling edge, advance model and queue at the rising edge.
  task automatic tick();
    bit pop;
    @(negedge clk_in);
    compare_all();
    pop = q_read;
    if (vggo) n_vggo++;
    if (q_read) n_qread++;
    if (frame_done) n_done++;
    @(posedge clk_in);
    model_step();
    #1;
    q_count = q_count - int'(pop) + push_n;
    if (q_count > QDEP) q_count = QDEP;
    q_empty = (q_count == 0);
    q_full  = (q_count >= QDEP);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy) break;
    end
    chk(name, busy, 0);
  endtask

  task automatic new_scenario();
    n_vggo = 0; n_qread = 0; n_done = 0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    int n;
    rst_in = 1'b1; frame_start = 1'b0; avg_halt = 1'b1; lr_write = 1'b0;
    q_empty = 1'b1; q_full = 1'b0; draw_ack = 1'b1; clr_status = 1'b0;
    model_reset();
    new_scenario();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_line_count", line_count, 0);
    frame_start = 1'b1;
    ticks(3);
    rst_in = 1'b0; frame_start = 1'b0;
    ticks(3);
    chk("start_lost_in_reset", n_vggo, 0);

    // normal frame: 5 lines, immediate ack
    new_scenario();
    pulse_start();
    ticks(19);
    avg_halt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_n = 1; tick(); push_n = 0; tick();
    end
    ticks(2);
    avg_halt = 1'b1;
    wait_idle("normal_idle");
    chk("normal_vggo_cnt", n_vggo, 1);
    chk("normal_qread_cnt", n_qread, 5);
    chk("normal_done_cnt", n_done, 1);
    chk("normal_frame_lines", frame_lines, 5);
    chk("normal_flags", {overrun, timeout, start_fail, drop}, 0);

    // backpressure: 3 lines held for 10 cycles without ack
    new_scenario();
    draw_ack = 1'b0;
    pulse_start();
    avg_halt = 1'b0;
    ticks(2);
    push_n = 1; ticks(3); push_n = 0;
    ticks(10);
    chk("bp_no_qread", n_qread, 0);
    chk("bp_draw_req", draw_req, 1);
    draw_ack = 1'b1; avg_halt = 1'b1;
    wait_idle("bp_idle");
    chk("bp_qread_cnt", n_qread, 3);
    chk("bp_frame_lines", frame_lines, 3);

    // start failure: halt never drops, 2 lines drained afterwards
    new_scenario();
    draw_ack = 1'b0; avg_halt = 1'b1;
    pulse_start();
    chk("sf_vggo", vggo, 1);
    n = 0;
    while (n < 200) begin
      push_n = (n < 2) ? 1 : 0;
      tick();
      n++;
      if (start_fail) break;
    end
    push_n = 0;
    chk("sf_latency", n, 49);
    draw_ack = 1'b1;
    wait_idle("sf_idle");
    chk("sf_done_cnt", n_done, 1);
    chk("sf_frame_lines", frame_lines, 2);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    chk("sf_cleared", start_fail, 0);

    // runaway: halt low from the start, timeout after 100 run cycles
    new_scenario();
    avg_halt = 1'b0;
    pulse_start();
    n = 0;
    while (n < 300) begin
      tick();
      n++;
      if (timeout) break;
    end
    chk("to_latency", n, 102);
    wait_idle("to_idle");
    chk("to_done_cnt", n_done, 1);
    chk("to_flag", timeout, 1);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    chk("to_cleared", timeout, 0);

    // overrun and drop
    new_scenario();
    draw_ack = 1'b0; avg_halt = 1'b1;
    pulse_start();
    avg_halt = 1'b0;
    ticks(2);
    pulse_start();
    chk("ovr_flag", overrun, 1);
    lr_write = 1'b1; tick(); lr_write = 1'b0; tick();
    chk("drop_not_full", drop, 0);
    push_n = 1; ticks(4); push_n = 0;
    lr_write = 1'b1; ticks(3); lr_write = 1'b0; tick();
    chk("drop_flag", drop, 1);
    draw_ack = 1'b1; avg_halt = 1'b1;
    wait_idle("ovr_idle");
    chk("ovr_vggo_cnt", n_vggo, 1);
    chk("ovr_frame_lines", frame_lines, 4);
    clr_status = 1'b1; tick(); clr_status = 1'b0;

    // async reset while draining with 2 entries queued
    new_scenario();
    draw_ack = 1'b0; avg_halt = 1'b1;
    pulse_start();
    avg_halt = 1'b0;
    ticks(2);
    push_n = 1; ticks(2); push_n = 0;
    avg_halt = 1'b1;
    ticks(3);
    chk("rd_busy_before", busy, 1);
    chk("rd_draw_req_before", draw_req, 1);
    #2;
    rst_in = 1'b1; frame_start = 1'b1;
    model_reset();
    #1;
    chk("rd_busy_now", busy, 0);
    chk("rd_draw_req_now", draw_req, 0);
    chk("rd_frame_lines_now", frame_lines, 0);
    ticks(2);
    rst_in = 1'b0; frame_start = 1'b0;
    ticks(5);
    chk("rd_no_done", n_done, 0);
    chk("rd_idle_after", busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/avg_frame_seq.md
AVG_FRAME_SEQ -- requirements
Module: avg_frame_seq

Interface
REQ-001 Parameter TIMEOUT, default 16'd50000, max clk_in cycles allowed in RUN before forced abort.
REQ-002 Parameter START_WAIT, default 6'd48, max clk_in cycles in ARM waiting for avg_halt to drop.
REQ-003 Parameter CNT_W, default 12, width of line counters.
REQ-004 Port clk_in  input  1  system clock; all state on rising edge.
REQ-005 Port rst_in  input  1  asynchronous, active-high reset.
REQ-006 Port frame_start  input  1  one-cycle frame-boundary pulse (vsync).
REQ-007 Port avg_halt  input  1  AVG core halt status.
REQ-008 Port lr_write  input  1  AVG line-register write strobe (level, may last several cycles).
REQ-009 Port q_empty  input  1  line queue empty.
REQ-010 Port q_full  input  1  line queue full.
REQ-011 Port draw_ack  input  1  line drawer accepts current queue head this cycle.
REQ-012 Port vggo  output  1  one-cycle AVG start pulse.
REQ-013 Port q_read  output  1  one-cycle queue pop.
REQ-014 Port draw_req  output  1  queue head valid to drawer.
REQ-015 Port busy  output  1  high in any state except IDLE.
REQ-016 Port frame_done  output  1  one-cycle end-of-frame pulse.
REQ-017 Port line_count  output  CNT_W  lines popped in current frame.
REQ-018 Port frame_lines  output  CNT_W  line_count latched at last frame end.
REQ-019 Port clr_status  input  1  clears sticky flags.
REQ-020 Port overrun, timeout, start_fail, drop  output  1 each  sticky error flags.

Function
REQ-021 States: IDLE, START, ARM, RUN, DRAIN, DONE, encoded in one state register.
REQ-022 IDLE: frame_start -> START; else hold.
REQ-023 START: vggo=1 for exactly this cycle; clear line_count and wait counter; -> ARM.
REQ-024 ARM: avg_halt==0 -> RUN; wait counter reaching START_WAIT -> set start_fail, -> DRAIN.
REQ-025 RUN: avg_halt==1 -> DRAIN; run counter reaching TIMEOUT -> set timeout, -> DRAIN.
REQ-026 DRAIN: q_empty==1 -> DONE.
REQ-027 DONE: frame_done=1, frame_lines<=line_count; -> IDLE next cycle.
REQ-028 draw_req = (state in ARM, RUN, DRAIN) and !q_empty, combinational.
REQ-029 q_read = draw_req and draw_ack; pops at most one entry per cycle.
REQ-030 Once asserted, draw_req holds until the head is acked; no transition may drop it.
REQ-031 line_count increments on each q_read; saturates at all-ones.
REQ-032 frame_start in any state other than IDLE: ignored, sets overrun.
REQ-033 drop set when rising edge of lr_write occurs while q_full==1 (edge-detect, one flag per edge).
REQ-034 Sticky flags clear on clr_status; a set event in the same cycle takes priority.
REQ-035 Run/wait counters are saturating, reset on entry to START; no wrap-around.

Reset
REQ-036 On rst_in: state=IDLE; vggo, q_read, draw_req, busy, frame_done = 0; line_count, frame_lines = 0; all sticky flags = 0; counters = 0; lr_write edge register = 0.
REQ-037 Reset asserted mid-frame aborts immediately; no frame_done is emitted for the aborted frame.
REQ-038 After rst_in deasserts, the first frame_start is required to start a frame; frame_start during reset is lost.

Verification
REQ-039 Normal frame: frame_start; avg_halt drops 20 cycles later; 5 lines acked immediately; avg_halt rises -> single vggo pulse, 5 q_read pulses, frame_done once, frame_lines=5, no flags.
REQ-040 Backpressure: 3 queued lines, draw_ack held low 10 cycles -> draw_req held high steady, no q_read until ack, line_count=3 at DONE.
REQ-041 Start failure: avg_halt stays 1 -> start_fail set after 48 cycles in ARM, queue drained, frame_done pulses.
REQ-042 Runaway: avg_halt never rises, TIMEOUT=100 -> timeout set at run cycle 100, DRAIN, frame_done; clr_status then clears timeout.
REQ-043 Overrun/drop: frame_start during RUN -> overrun=1, no second vggo; lr_write rising while q_full -> drop=1.
REQ-044 Async reset in DRAIN with 2 entries queued -> outputs zero immediately, no frame_done, IDLE after release.
